counter_load_arbiter: RTL and testbench
=======================================

// Module: counter_load_arbiter
// PURPOSE
//  Round-robin controller that shares the reload port of a 4-bit wrap counter between N requesters.
//  Each requester asks to have its value loaded at the counter's next terminal count (all ones).
//  The block picks one winner and drives load_o/load_val_o into the counter.
//  It waits for the terminal-count edge, then acknowledges the winner and checks that the counter reloaded.
//  Sits between requesting agents and the counter; count_i is the counter's count_o.
// PARAMETERS
//  N_REQ   4   number of requesters (2..8)
//  WIDTH   4   counter width; terminal count TC = {WIDTH{1'b1}}
// PORTS
//  clk         in   1              rising-edge clock
//  reset       in   1              asynchronous, active-low reset
//  req_i       in   N_REQ          per-requester load request; level, held until gnt_o or withdrawn
//  val_i       in   N_REQ*WIDTH    load values; requester k uses val_i[k*WIDTH +: WIDTH]
//  count_i     in   WIDTH          current counter value
//  load_o      out  1              load enable to counter
//  load_val_o  out  WIDTH          value to load
//  gnt_o       out  N_REQ          one-hot, one-cycle completion pulse to winner
//  owner_o     out  $clog2(N_REQ)  index of current winner (valid while busy_o)
//  busy_o      out  1              high in ARMED and DONE
//  err_o       out  1              sticky: counter did not take the loaded value
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, rr_ptr=0, load_o=0, load_val_o=0, gnt_o=0, owner_o=0, busy_o=0, err_o=0.
//  Counter contract: the counter loads load_val_o at an edge where load_o==1 and count_i==TC; otherwise it wraps to 0 or increments.
//  States:
//   IDLE  : if |req_i at edge -> capture winner and val_i slice into owner_o/load_val_o -> ARMED; else stay.
//           Winner = first set req at or after rr_ptr, circular.
//   ARMED : load_o=1, busy_o=1. At an edge:
//           - if req_i[owner_o]==0 -> abort: IDLE, load_o=0, no gnt, rr_ptr unchanged.
//           - else if count_i==TC -> DONE (counter loads at this same edge).
//           - else stay. Abort has priority only when req drops in the same cycle TC is seen.
//   DONE  : 1 cycle. load_o=0, gnt_o[owner_o]=1, busy_o=1.
//           If count_i!=load_val_o, set err_o (sticky until reset).
//           rr_ptr <= owner_o+1 mod N_REQ. Next state IDLE.
//  load_val_o and owner_o are frozen from capture until return to IDLE; val_i changes in ARMED are ignored.
//  Latency: req sampled in IDLE at edge k -> load_o high from k+1.
//   - TC seen at edge k+1 -> gnt_o pulse in cycle k+1..k+2.
//   - Minimum req->gnt is 2 edges; maximum is 2^WIDTH+1 edges.
//  Back-to-back: after DONE there is always one IDLE cycle before the next ARMED (no arbitration in DONE).
//  load_val_o==TC is legal; the counter then hits TC immediately again, but no second load occurs (load_o=0 in DONE).
//  Reset asserted mid-ARMED/DONE: immediate return to reset values; no gnt issued; the pending request is lost.
//  gnt_o is never asserted for a withdrawn request; never more than one bit set.
// TESTING
//  1 Reset: hold reset=0 with req_i=4'b1111 -> all outputs 0, state IDLE.
//    Release -> owner_o=0, load_o=1 next cycle.
//  2 Single req: req_i[2]=1, val=4'h5, counter at 4'hC -> load_o high 4 cycles.
//    Counter shows 4'h5 after TC; gnt_o=4'b0100 for exactly 1 cycle; err_o=0.
//  3 Round-robin: req_i=4'b1011 held continuously, re-raised after each gnt -> grant order 0,1,3,0,1,3.
//    Requester 2 is never granted.
//  4 Withdrawal: req_i[1] raised, then dropped while ARMED and before TC -> load_o falls, no gnt.
//    Counter wraps to 0 at TC.
//  5 Load-miss check: counter model ignores load_o once -> after DONE count_i=0 != load_val_o, so err_o=1 and stays 1.
//  6 Mid-op reset: reset=0 for 1 cycle during ARMED -> load_o=0 asynchronously; rr_ptr=0; no gnt_o pulse.

Source files
------------

// File: rtl/counter_load_arbiter_if.sv
// ---------------------------------------------------------------------------
// counter_load_arbiter_if
//
// Bundles the request side and the counter side of counter_load_arbiter.
//
//   req_i       per-requester load request (level)
//   val_i       packed load values, requester k at val_i[k*WIDTH +: WIDTH]
//   count_i     current value of the shared wrap counter
//   load_o      load enable into the counter
//   load_val_o  value the counter loads when it takes the load
//   gnt_o       one-hot completion pulse to the winning requester
//   owner_o     index of the current winner
//   busy_o      a load is armed or just completed
//   err_o       sticky flag: the counter did not take a loaded value
//
// slave  : the arbiter's view
// master : the view of whatever drives requests and hosts the counter
// ---------------------------------------------------------------------------
interface counter_load_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
);
    localparam int OWNER_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_i;
    logic [N_REQ*WIDTH-1:0] val_i;
    logic [WIDTH-1:0]       count_i;
    logic                   load_o;
    logic [WIDTH-1:0]       load_val_o;
    logic [N_REQ-1:0]       gnt_o;
    logic [OWNER_W-1:0]     owner_o;
    logic                   busy_o;
    logic                   err_o;

    modport slave (
        input  req_i, val_i, count_i,
        output load_o, load_val_o, gnt_o, owner_o, busy_o, err_o
    );

    modport master (
        output req_i, val_i, count_i,
        input  load_o, load_val_o, gnt_o, owner_o, busy_o, err_o
    );
endinterface

// File: rtl/counter_load_arbiter.sv
// ---------------------------------------------------------------------------
// counter_load_arbiter
//
// Round-robin owner of the reload port of a WIDTH-bit wrap counter shared by
// N_REQ requesters. A winner is picked in IDLE, its value is presented on
// load_val_o with load_o high until the counter reaches terminal count (the
// counter reloads on that edge), then the winner gets a one-cycle gnt_o and
// the reloaded count is checked against the value that was offered.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    counter_load_arbiter_if.slave (requests, counter value, load
//          enable/value, grant, owner, busy, sticky error)
// ---------------------------------------------------------------------------
module counter_load_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    counter_load_arbiter_if.slave   bus
);

    localparam int              OWNER_W = $clog2(N_REQ);
    localparam logic [WIDTH-1:0] TC      = {WIDTH{1'b1}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]         state_q,    state_d;
    logic [OWNER_W-1:0] rr_ptr_q,   rr_ptr_d;
    logic [OWNER_W-1:0] owner_q,    owner_d;
    logic [WIDTH-1:0]   load_val_q, load_val_d;
    logic               err_q,      err_d;

    logic               win_found;
    logic [OWNER_W-1:0] win_idx;
    logic [WIDTH-1:0]   win_val;
    logic [OWNER_W:0]   cand;
    logic [N_REQ-1:0]   gnt;

    // Circular search for the first active request at or after rr_ptr.
    // cand is one bit wider so rr_ptr + offset can be folded back below N_REQ
    // without relying on N_REQ being a power of two.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (OWNER_W+1)'(i);
            if (cand >= (OWNER_W+1)'(N_REQ)) begin
                cand = cand - (OWNER_W+1)'(N_REQ);
            end
            if (!win_found && bus.req_i[cand[OWNER_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[OWNER_W-1:0];
            end
        end
    end

    always_comb begin
        win_val = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_idx == OWNER_W'(k)) begin
                win_val = bus.val_i[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        load_val_d = load_val_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                // owner and value are captured here and then frozen, so
                // val_i may change freely while the load is armed.
                if (win_found) begin
                    owner_d    = win_idx;
                    load_val_d = win_val;
                    state_d    = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // A withdrawn request wins even on the terminal-count edge:
                // no grant may be issued for a request that is gone.
                if (!bus.req_i[owner_q]) begin
                    state_d = ST_IDLE;
                end else if (bus.count_i == TC) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // The counter should now hold the value it was offered.
                if (bus.count_i != load_val_q) begin
                    err_d = 1'b1;
                end
                rr_ptr_d = (owner_q == OWNER_W'(N_REQ-1)) ? '0 : owner_q + OWNER_W'(1);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            load_val_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            load_val_q <= load_val_d;
            err_q      <= err_d;
        end
    end

    // Outputs are decoded straight from the state flops so an asynchronous
    // reset drops load_o and gnt_o immediately.
    always_comb begin
        gnt = '0;
        for (int k = 0; k < N_REQ; k++) begin
            gnt[k] = (state_q == ST_DONE) && (owner_q == OWNER_W'(k));
        end
    end

    assign bus.load_o     = (state_q == ST_ARMED);
    assign bus.busy_o     = (state_q == ST_ARMED) || (state_q == ST_DONE);
    assign bus.load_val_o = load_val_q;
    assign bus.owner_o    = owner_q;
    assign bus.err_o      = err_q;
    assign bus.gnt_o      = gnt;

endmodule

// File: tb/tb_counter_load_arbiter.sv
// ---------------------------------------------------------------------------
// tb_counter_load_arbiter
//
// Directed bench for counter_load_arbiter with N_REQ=4, WIDTH=4. A small
// behavioural wrap counter consumes load_o/load_val_o and can be preset or
// told to ignore a load.
// ---------------------------------------------------------------------------
module tb_counter_load_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 4;

    logic clk;
    logic reset;

    int tests;
    int fails;

    logic [3:0] cnt;
    logic       preset_en;
    logic [3:0] preset_val;
    logic       miss_en;

    logic [31:0] exp_gnt [6];
    logic [31:0] exp_val [6];

    counter_load_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

    counter_load_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wrap counter following the load contract; preset_en forces a value,
    // miss_en makes it ignore a load that would otherwise happen.
    always @(posedge clk) begin
        if (preset_en) begin
            cnt <= preset_val;
        end else if (bus.load_o && cnt == 4'hF && !miss_en) begin
            cnt <= bus.load_val_o;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

    assign bus.count_i = cnt;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] req, input logic [15:0] val);
        bus.req_i = req;
        bus.val_i = val;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests      = 0;
        fails      = 0;
        reset      = 1'b0;
        miss_en    = 1'b0;
        preset_en  = 1'b1;
        preset_val = 4'h0;
        apply_stimulus(4'b1111, 16'h0000);
        exp_gnt = '{32'h1, 32'h2, 32'h8, 32'h1, 32'h2, 32'h8};
        exp_val = '{32'h4, 32'h9, 32'h7, 32'h4, 32'h9, 32'h7};

        // Reset held with all requests high
        @(negedge clk);
        preset_en = 1'b0;
        @(negedge clk);
        check_output("rst_load",     32'(bus.load_o),     0);
        check_output("rst_load_val", 32'(bus.load_val_o), 0);
        check_output("rst_gnt",      32'(bus.gnt_o),      0);
        check_output("rst_owner",    32'(bus.owner_o),    0);
        check_output("rst_busy",     32'(bus.busy_o),     0);
        check_output("rst_err",      32'(bus.err_o),      0);

        reset = 1'b1;
        @(negedge clk);
        check_output("rel_owner", 32'(bus.owner_o), 0);
        check_output("rel_load",  32'(bus.load_o),  1);
        check_output("rel_busy",  32'(bus.busy_o),  1);
        apply_stimulus(4'b0000, 16'h0000);
        @(negedge clk);
        check_output("rel_abort_load", 32'(bus.load_o), 0);
        check_output("rel_abort_busy", 32'(bus.busy_o), 0);
        check_output("rel_abort_gnt",  32'(bus.gnt_o),  0);

        // Single request from requester 2, counter starting at C
        apply_stimulus(4'b0100, 16'h0500);
        preset_val = 4'hC;
        preset_en  = 1'b1;
        @(negedge clk);
        preset_en = 1'b0;
        check_output("single_load0",    32'(bus.load_o),     1);
        check_output("single_owner",    32'(bus.owner_o),    2);
        check_output("single_load_val", 32'(bus.load_val_o), 32'h5);
        apply_stimulus(4'b0100, 16'h0A00);
        repeat (3) begin
            @(negedge clk);
            check_output("single_load_hold", 32'(bus.load_o), 1);
            check_output("single_no_gnt",    32'(bus.gnt_o),  0);
        end
        @(negedge clk);
        check_output("single_gnt",      32'(bus.gnt_o),  32'h4);
        check_output("single_done_ld",  32'(bus.load_o), 0);
        check_output("single_done_bsy", 32'(bus.busy_o), 1);
        check_output("single_count",    32'(cnt),        32'h5);
        apply_stimulus(4'b0000, 16'h0000);
        @(negedge clk);
        check_output("single_gnt_off", 32'(bus.gnt_o),  0);
        check_output("single_idle",    32'(bus.busy_o), 0);
        check_output("single_err",     32'(bus.err_o),  0);

        // Round-robin with requesters 0,1,3 held; start from a fresh pointer
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(4'b1011, 16'h7294);
        preset_val = 4'hE;
        preset_en  = 1'b1;
        @(negedge clk);
        preset_en = 1'b0;
        for (int g = 0; g < 6; g++) begin
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (bus.gnt_o != 4'b0000) break;
            end
            check_output("rr_gnt",   32'(bus.gnt_o), exp_gnt[g]);
            check_output("rr_count", 32'(cnt),       exp_val[g]);
        end
        apply_stimulus(4'b0000, 16'h7294);
        @(negedge clk);
        check_output("rr_err",  32'(bus.err_o),  0);
        check_output("rr_idle", 32'(bus.busy_o), 0);

        // Load value equal to terminal count: no second load after DONE
        apply_stimulus(4'b0001, 16'h729F);
        preset_val = 4'hE;
        preset_en  = 1'b1;
        @(negedge clk);
        preset_en = 1'b0;
        check_output("tcval_load_val", 32'(bus.load_val_o), 32'hF);
        @(negedge clk);
        @(negedge clk);
        check_output("tcval_gnt",   32'(bus.gnt_o), 32'h1);
        check_output("tcval_count", 32'(cnt),       32'hF);
        apply_stimulus(4'b0000, 16'h7294);
        @(negedge clk);
        check_output("tcval_wrap", 32'(cnt),          0);
        check_output("tcval_load", 32'(bus.load_o),   0);
        check_output("tcval_err",  32'(bus.err_o),    0);

        // Withdrawal before terminal count
        apply_stimulus(4'b0010, 16'h7294);
        preset_val = 4'hD;
        preset_en  = 1'b1;
        @(negedge clk);
        preset_en = 1'b0;
        check_output("wd_load",  32'(bus.load_o),  1);
        check_output("wd_owner", 32'(bus.owner_o), 1);
        apply_stimulus(4'b0000, 16'h7294);
        @(negedge clk);
        check_output("wd_load_off", 32'(bus.load_o), 0);
        check_output("wd_no_gnt0",  32'(bus.gnt_o),  0);
        @(negedge clk);
        check_output("wd_no_gnt1",  32'(bus.gnt_o),  0);
        @(negedge clk);
        check_output("wd_wrap",     32'(cnt),        0);
        check_output("wd_no_gnt2",  32'(bus.gnt_o),  0);

        // Withdrawal in the same cycle terminal count is seen
        apply_stimulus(4'b0010, 16'h7294);
        preset_val = 4'hE;
        preset_en  = 1'b1;
        @(negedge clk);
        preset_en = 1'b0;
        @(negedge clk);
        check_output("wdtc_load", 32'(bus.load_o), 1);
        apply_stimulus(4'b0000, 16'h7294);
        @(negedge clk);
        check_output("wdtc_no_gnt", 32'(bus.gnt_o),  0);
        check_output("wdtc_idle",   32'(bus.busy_o), 0);
        check_output("wdtc_load_off", 32'(bus.load_o), 0);

        // Counter ignores one load: sticky error
        apply_stimulus(4'b0001, 16'h7294);
        preset_val = 4'hE;
        preset_en  = 1'b1;
        miss_en    = 1'b1;
        @(negedge clk);
        preset_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_output("miss_gnt",   32'(bus.gnt_o), 32'h1);
        check_output("miss_count", 32'(cnt),       0);
        apply_stimulus(4'b0000, 16'h7294);
        miss_en = 1'b0;
        @(negedge clk);
        check_output("miss_err_set", 32'(bus.err_o), 1);
        repeat (3) @(negedge clk);
        check_output("miss_err_sticky", 32'(bus.err_o), 1);

        // Reset pulse while ARMED
        apply_stimulus(4'b0100, 16'h7294);
        preset_val = 4'h0;
        preset_en  = 1'b1;
        @(negedge clk);
        preset_en = 1'b0;
        check_output("mid_load",  32'(bus.load_o),  1);
        check_output("mid_owner", 32'(bus.owner_o), 2);
        #2;
        reset = 1'b0;
        #1;
        check_output("mid_rst_load",  32'(bus.load_o),  0);
        check_output("mid_rst_busy",  32'(bus.busy_o),  0);
        check_output("mid_rst_owner", 32'(bus.owner_o), 0);
        check_output("mid_rst_err",   32'(bus.err_o),   0);
        check_output("mid_rst_gnt",   32'(bus.gnt_o),   0);
        apply_stimulus(4'b0000, 16'h7294);
        @(negedge clk);
        check_output("mid_rst_gnt2", 32'(bus.gnt_o), 0);
        reset = 1'b1;
        apply_stimulus(4'b1111, 16'h7294);
        @(negedge clk);
        check_output("mid_ptr_owner", 32'(bus.owner_o), 0);
        check_output("mid_ptr_load",  32'(bus.load_o),  1);
        apply_stimulus(4'b0000, 16'h7294);
        @(negedge clk);
        check_output("mid_end_load", 32'(bus.load_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
